// File: rtl/alu_pkg.sv
// Shared ALU definitions: arbiter state encoding, round-robin pointer sizing
// and the default datapath width.
package alu_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  // A pointer still needs one bit when there is only one requester.
  function automatic int rr_ptr_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: returns the one-hot winner, which is the
// first set request bit at or after the pointer, wrapping modulo R.
module rr_select
  import alu_pkg::*;
#(
  parameter int R  = 3,
  parameter int PW = rr_ptr_width(R)
) (
  input  logic [R-1:0]  request,
  input  logic [PW-1:0] pointer,
  output logic [R-1:0]  winner
);

  logic [PW-1:0] idx;

  // NOTE: every variable written here gets a default before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    idx    = '0;
    // Walk from farthest to nearest so the nearest hit overwrites the rest.
    for (int i = R - 1; i >= 0; i--) begin
      idx = PW'((int'(pointer) + i) % R);
      if (request[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/resource_arbiter.sv
// Round-robin owner arbiter for the shared ALU adder/comparator pair.
// Define RESOURCE_ARBITER_TIMEOUT_EN to add the MAX_HOLD grant timeout and o_timeout.
module resource_arbiter
  import alu_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int R        = 3,
  parameter int MAX_HOLD = 255
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic [R-1:0]   i_request,
  output logic [R-1:0]   o_grant,
  input  logic [R*N-1:0] i_augend,
  input  logic [R*N-1:0] i_addend,
  input  logic [R*N-1:0] i_left,
  input  logic [R*N-1:0] i_right,
  output logic [R*N-1:0] o_sum,
  output logic [R-1:0]   o_equal,
  output logic [N-1:0]   o_adder_augend,
  output logic [N-1:0]   o_adder_addend,
  input  logic [N-1:0]   i_adder_sum,
  output logic [N-1:0]   o_comparator_left,
  output logic [N-1:0]   o_comparator_right,
  input  logic           i_comparator_equal,
`ifdef RESOURCE_ARBITER_TIMEOUT_EN
  output logic           o_timeout,
`endif
  output logic           o_busy
);

  localparam int PW = rr_ptr_width(R);

  arb_state_e    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner_idx;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] sel_ptr;
  logic [R-1:0]  cand_req;
  logic [R-1:0]  winner;
  logic          owner_req;
  logic          release_now;

`ifdef RESOURCE_ARBITER_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  logic [R-1:0]  blocked;
  logic          timeout_hit;

  // Fires on the edge that would bring the hold count up to MAX_HOLD.
  assign timeout_hit = (state == ARB_OWNED) && owner_req &&
                       (hold_cnt == HW'(MAX_HOLD - 1));
`endif

  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < R; k++) begin
      if (o_grant[k]) owner_idx = PW'(k);
    end
  end

  assign owner_req = |(o_grant & i_request);
  assign next_ptr  = (owner_idx == PW'(R - 1)) ? '0 : owner_idx + 1'b1;
  // While owned, arbitration only matters on release and then uses the advanced pointer.
  assign sel_ptr   = (state == ARB_OWNED) ? next_ptr : ptr;

`ifdef RESOURCE_ARBITER_TIMEOUT_EN
  assign release_now = (state == ARB_OWNED) && (!owner_req || timeout_hit);
  assign cand_req    = i_request & ~blocked & ~(timeout_hit ? o_grant : '0);
`else
  assign release_now = (state == ARB_OWNED) && !owner_req;
  assign cand_req    = i_request;
`endif

  rr_select #(.R(R), .PW(PW)) u_rr_select (
    .request (cand_req),
    .pointer (sel_ptr),
    .winner  (winner)
  );

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ARB_IDLE;
      o_grant  <= '0;
      ptr      <= '0;
`ifdef RESOURCE_ARBITER_TIMEOUT_EN
      hold_cnt  <= '0;
      blocked   <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
      if (state == ARB_IDLE || release_now) begin
        o_grant <= winner;
        state   <= (|cand_req) ? ARB_OWNED : ARB_IDLE;
        if (release_now) ptr <= next_ptr;
      end
`ifdef RESOURCE_ARBITER_TIMEOUT_EN
      if (state == ARB_IDLE || release_now) hold_cnt <= '0;
      else                                  hold_cnt <= hold_cnt + 1'b1;
      // A revoked unit stays locked out until it drops its request once.
      blocked   <= (blocked & i_request) | (timeout_hit ? o_grant : '0);
      o_timeout <= timeout_hit;
`endif
    end
  end

  always_comb begin
    o_adder_augend     = '0;
    o_adder_addend     = '0;
    o_comparator_left  = '0;
    o_comparator_right = '0;
    o_sum              = '0;
    o_equal            = '0;
    for (int k = 0; k < R; k++) begin
      if (o_grant[k]) begin
        o_adder_augend     = i_augend[k*N +: N];
        o_adder_addend     = i_addend[k*N +: N];
        o_comparator_left  = i_left[k*N +: N];
        o_comparator_right = i_right[k*N +: N];
        o_sum[k*N +: N]    = i_adder_sum;
        o_equal[k]         = i_comparator_equal;
      end
    end
  end

  assign o_busy = |o_grant;

endmodule
